// File: rtl/brp_pkg.sv
// Shared definitions for the gshare branch predictor slice: default widths,
// resolve-FSM state encodings, the prediction record layout and the BHT index
// helper used on the predictor side.
package brp_pkg;

  localparam int PC_W_DEF  = 32;
  localparam int IDX_W_DEF = 8;

  // Resolve FSM encodings, kept as plain constants for older tools.
  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  // One in-flight prediction, as captured at fetch, at the default widths.
  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic                taken;
    logic [PC_W_DEF-1:0] target;
  } pred_rec_t;

  // Word-aligned PC bits that address the BHT at the default widths.
  function automatic logic [IDX_W_DEF-1:0] bht_idx(input logic [PC_W_DEF-1:0] pc);
    return pc[IDX_W_DEF+1:2];
  endfunction

endpackage

// File: rtl/brq_fifo.sv
// In-order queue of outstanding prediction records. Pointers carry one extra
// wrap bit so full and empty can be told apart without a separate counter.
// Clear wins over push and pop so a mispredict drops every younger record.
module brq_fifo
  import brp_pkg::*;
#(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign head_data = mem[rd_ptr[AW-1:0]];

  // Pointer bookkeeping; the caller only pushes when not full and pops when not empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Record storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolve side of the gshare predictor. Matches each EX outcome against the
// oldest queued prediction, trains the BHT/GHR through a registered update
// pulse, and on a mispredict flushes the pipeline, redirects fetch and spends
// one cycle in FLUSH so the wrong-path push already in flight is dropped.
module branch_resolve_unit
  import brp_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [PC_W-1:0]  pred_pc,
  input  logic             pred_taken,
  input  logic [PC_W-1:0]  pred_target,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [PC_W-1:0]  res_target,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_address,
  output logic             upd_taken,
  output logic             flush,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic             proto_err
);

  localparam int REC_W = 2 * PC_W + 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } rec_t;

  logic state;
  logic full;
  logic empty;
  rec_t push_rec;
  rec_t head_rec;
  logic [REC_W-1:0] head_bits;

  logic do_push;
  logic do_resolve;
  logic mis;
  logic empty_res;
  logic [PC_W-1:0] next_redirect;

  assign push_rec = '{pc: pred_pc, taken: pred_taken, target: pred_target};
  assign head_rec = rec_t'(head_bits);

  assign pred_ready = (state == ST_RUN) && !full;

  // Decide this cycle's queue actions and whether the head was mispredicted.
  always_comb begin
    do_resolve    = 1'b0;
    mis           = 1'b0;
    empty_res     = 1'b0;
    do_push       = 1'b0;
    next_redirect = res_target;
    if (state == ST_RUN && res_valid) begin
      if (empty) begin
        empty_res = 1'b1;
      end else begin
        do_resolve = 1'b1;
        mis = (head_rec.taken != res_taken) ||
              (res_taken && (head_rec.target != res_target));
      end
    end
    if (!res_taken) next_redirect = head_rec.pc + PC_W'(4);
    do_push = pred_valid && pred_ready && !(do_resolve && mis);
  end

  brq_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (do_push),
    .push_data (push_rec),
    .pop       (do_resolve),
    .clear     (do_resolve && mis),
    .head_data (head_bits),
    .full      (full),
    .empty     (empty)
  );

  // RUN/FLUSH sequencing: a mispredict buys exactly one FLUSH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else if (state == ST_FLUSH) begin
      state <= ST_RUN;
    end else if (do_resolve && mis) begin
      state <= ST_FLUSH;
    end
  end

  // Registered training and redirect outputs; pulses last one cycle, the rest hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid   <= 1'b0;
      upd_address <= '0;
      upd_taken   <= 1'b0;
      flush       <= 1'b0;
      redirect_pc <= '0;
    end else begin
      upd_valid <= do_resolve;
      flush     <= do_resolve && mis;
      if (do_resolve) begin
        upd_address <= head_rec.pc[IDX_W+1:2];
        upd_taken   <= res_taken;
      end
      if (do_resolve && mis) redirect_pc <= next_redirect;
    end
  end

  // Saturating statistics and the sticky protocol-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (do_resolve && (branch_cnt != {CNT_W{1'b1}}))
        branch_cnt <= branch_cnt + 1'b1;
      if (do_resolve && mis && (mispred_cnt != {CNT_W{1'b1}}))
        mispred_cnt <= mispred_cnt + 1'b1;
      if (empty_res) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit. Stimulus queues the expected update
// for every resolve it issues; a monitor pops and compares whenever the DUT
// raises upd_valid. A narrow counter width exposes saturation quickly.
module tb_branch_resolve_unit;

  localparam int PC_W  = 32;
  localparam int IDX_W = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             pred_valid;
  logic             pred_ready;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_address;
  logic             upd_taken;
  logic             flush;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;
  logic             proto_err;

  typedef struct {
    logic [IDX_W-1:0] addr;
    logic             taken;
    logic             fl;
    logic [PC_W-1:0]  redir;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  branch_resolve_unit #(
    .PC_W  (PC_W),
    .IDX_W (IDX_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pred_valid  (pred_valid),
    .pred_ready  (pred_ready),
    .pred_pc     (pred_pc),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .res_valid   (res_valid),
    .res_taken   (res_taken),
    .res_target  (res_target),
    .upd_valid   (upd_valid),
    .upd_address (upd_address),
    .upd_taken   (upd_taken),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, changing them on the falling edge.
  task automatic applyStimulus(input logic pv, input logic [31:0] ppc, input logic pt,
                               input logic [31:0] ptg, input logic rv, input logic rt,
                               input logic [31:0] rtg);
    @(negedge clk);
    pred_valid  = pv;
    pred_pc     = ppc;
    pred_taken  = pt;
    pred_target = ptg;
    res_valid   = rv;
    res_taken   = rt;
    res_target  = rtg;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic pushRec(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    applyStimulus(1'b1, pc, t, tgt, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic resolveExp(input logic t, input logic [31:0] tgt, input logic [7:0] addr,
                            input logic fl, input logic [31:0] redir);
    exp_t e;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, t, tgt);
    e.addr = addr; e.taken = t; e.fl = fl; e.redir = redir;
    sb.push_back(e);
  endtask

  // Monitor: every update pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (upd_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_upd_valid", 32'(upd_valid), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("upd_address", 32'(upd_address), 32'(e.addr));
          checkOutput("upd_taken", 32'(upd_taken), 32'(e.taken));
          checkOutput("flush", 32'(flush), 32'(e.fl));
          if (e.fl) checkOutput("redirect_pc", redirect_pc, e.redir);
        end
      end else if (flush) begin
        checkOutput("flush_without_upd", 32'(flush), 32'h0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_target = '0;
    res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_upd_valid", 32'(upd_valid), 32'h0);
    checkOutput("rst_flush", 32'(flush), 32'h0);
    checkOutput("rst_redirect", redirect_pc, 32'h0);
    checkOutput("rst_branch_cnt", 32'(branch_cnt), 32'h0);
    checkOutput("rst_mispred_cnt", 32'(mispred_cnt), 32'h0);
    checkOutput("rst_proto_err", 32'(proto_err), 32'h0);
    checkOutput("rst_pred_ready", 32'(pred_ready), 32'h1);

    $display("[TB] correct taken prediction");
    pushRec(32'h100, 1'b1, 32'h200);
    resolveExp(1'b1, 32'h200, 8'h40, 1'b0, 32'h0);
    idle();
    checkOutput("t1_branch_cnt", 32'(branch_cnt), 32'd1);
    checkOutput("t1_mispred_cnt", 32'(mispred_cnt), 32'd0);

    $display("[TB] direction mispredict, actually taken");
    pushRec(32'h104, 1'b0, 32'h0);
    resolveExp(1'b1, 32'h300, 8'h41, 1'b1, 32'h300);
    applyStimulus(1'b1, 32'h500, 1'b1, 32'h600, 1'b1, 1'b1, 32'h600);
    checkOutput("t2_pred_ready_flush", 32'(pred_ready), 32'h0);
    checkOutput("t2_mispred_cnt", 32'(mispred_cnt), 32'd1);
    checkOutput("t2_redirect_hold", redirect_pc, 32'h300);
    idle();
    checkOutput("t2_pred_ready_back", 32'(pred_ready), 32'h1);
    checkOutput("t2_flush_pulse_end", 32'(flush), 32'h0);
    checkOutput("t2_proto_err_in_flush", 32'(proto_err), 32'h0);
    checkOutput("t2_branch_cnt", 32'(branch_cnt), 32'd2);

    $display("[TB] direction mispredict, actually not taken");
    pushRec(32'h108, 1'b1, 32'h400);
    resolveExp(1'b0, 32'h0, 8'h42, 1'b1, 32'h10C);
    idle();
    idle();
    checkOutput("t3_redirect", redirect_pc, 32'h10C);
    checkOutput("t3_mispred_cnt", 32'(mispred_cnt), 32'd2);

    $display("[TB] target-only mispredict");
    pushRec(32'h10C, 1'b1, 32'h200);
    resolveExp(1'b1, 32'h204, 8'h43, 1'b1, 32'h204);
    idle();
    idle();
    checkOutput("t3b_branch_cnt", 32'(branch_cnt), 32'd4);
    checkOutput("t3b_mispred_cnt", 32'(mispred_cnt), 32'd3);

    $display("[TB] fill queue, push while full, in-order retire");
    for (int i = 0; i < 4; i++) pushRec(32'h200 + 32'(4 * i), 1'b1, 32'h240 + 32'(4 * i));
    idle();
    checkOutput("t4_pred_ready_full", 32'(pred_ready), 32'h0);
    applyStimulus(1'b1, 32'h210, 1'b1, 32'h250, 1'b1, 1'b1, 32'h240);
    begin
      exp_t e;
      e.addr = 8'h80; e.taken = 1'b1; e.fl = 1'b0; e.redir = 32'h0;
      sb.push_back(e);
    end
    idle();
    checkOutput("t4_pred_ready_after_pop", 32'(pred_ready), 32'h1);
    checkOutput("t4_branch_cnt_5", 32'(branch_cnt), 32'd5);
    resolveExp(1'b1, 32'h244, 8'h81, 1'b0, 32'h0);
    resolveExp(1'b1, 32'h248, 8'h82, 1'b0, 32'h0);
    resolveExp(1'b1, 32'h24C, 8'h83, 1'b0, 32'h0);
    idle();
    idle();
    checkOutput("t4_branch_cnt_sat", 32'(branch_cnt), 32'd7);
    checkOutput("t4_mispred_cnt", 32'(mispred_cnt), 32'd3);

    $display("[TB] resolve with empty queue");
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h900);
    idle();
    checkOutput("t5_proto_err_set", 32'(proto_err), 32'h1);
    checkOutput("t5_upd_valid", 32'(upd_valid), 32'h0);
    idle();
    idle();
    checkOutput("t5_proto_err_sticky", 32'(proto_err), 32'h1);
    checkOutput("t5_branch_cnt", 32'(branch_cnt), 32'd7);

    $display("[TB] reset mid-operation");
    pushRec(32'h300, 1'b1, 32'h340);
    pushRec(32'h304, 1'b1, 32'h344);
    pushRec(32'h308, 1'b1, 32'h348);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #2 rst_n = 1'b0;
    idle();
    checkOutput("t6_upd_valid", 32'(upd_valid), 32'h0);
    checkOutput("t6_flush", 32'(flush), 32'h0);
    checkOutput("t6_redirect", redirect_pc, 32'h0);
    checkOutput("t6_upd_address", 32'(upd_address), 32'h0);
    checkOutput("t6_branch_cnt", 32'(branch_cnt), 32'h0);
    checkOutput("t6_mispred_cnt", 32'(mispred_cnt), 32'h0);
    checkOutput("t6_proto_err", 32'(proto_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
    idle();
    checkOutput("t6_queue_empty", 32'(proto_err), 32'h1);
    checkOutput("t6_branch_cnt_after", 32'(branch_cnt), 32'h0);
    idle();
    idle();

    checkOutput("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
